// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO decode constants and status-word packing for dmem_responder
package dmem_pkg;
  localparam logic [3:0] MMIO_BASE_NIBBLE = 4'hF;
  localparam logic [3:0] OFF_CYCLE = 4'h0;
  localparam logic [3:0] OFF_CONSOLE = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_COUNT_LSB = 8;
  function automatic logic [31:0] status_word(input logic [7:0] count, input logic ovf, input logic full, input logic empty);
    status_word = '0;
    status_word[ST_COUNT_LSB +: 8] = count;
    status_word[ST_OVF] = ovf;
    status_word[ST_FULL] = full;
    status_word[ST_EMPTY] = empty;
  endfunction
endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// sync_fifo: registered FIFO with head-of-queue output; a push into a full FIFO succeeds only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop = push && !do_push;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // Empty reads as zero so the head byte has a defined reset value without clearing storage
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus MMIO cycle counter, console FIFO and status; DMEM_MISALIGN_CHECK_EN enables misaligned-store trapping
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        err_misaligned
);
  logic [31:0] ram [2**ADDR_W];
  logic [31:0] cycle;
  logic [ADDR_W-1:0] idx;
  logic [3:0] off;
  logic mmio, store, push, ovf, full, empty, drop;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic unused_addr;
  assign unused_addr = ^ALUOutM;
  assign mmio = ALUOutM[31:28] == MMIO_BASE_NIBBLE;
  assign idx = ALUOutM[ADDR_W+1:2];
  assign off = ALUOutM[3:0];
`ifdef DMEM_MISALIGN_CHECK_EN
  logic err;
  assign store = MemWriteM && ALUOutM[1:0] == 2'b00;
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (MemWriteM && |ALUOutM[1:0]) err <= 1'b1;
  end
  assign err_misaligned = err;
`else
  assign store = MemWriteM;
  assign err_misaligned = 1'b0;
`endif
  assign push = store && mmio && off == OFF_CONSOLE;
  assign con_valid = !empty;
  // RAM is deliberately outside reset so stores in the reset cycle still land
  always_ff @(posedge clk) begin
    if (store && !mmio) ram[idx] <= WriteDataM;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      ovf <= 1'b0;
    end else begin
      cycle <= cycle + 1'b1;
      if (store && mmio && off == OFF_STATUS && WriteDataM[ST_OVF]) ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end
  always_comb begin
    ReadDataM = !mmio ? ram[idx] :
                off == OFF_CYCLE ? cycle :
                off == OFF_STATUS ? status_word(8'(count), ovf, full, empty) : '0;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(con_valid && con_ready),
    .din(WriteDataM[7:0]),
    .dout(con_data),
    .count(count),
    .full(full),
    .empty(empty),
    .drop(drop)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench; console bytes are queued on push and compared on each handshake
module tb_dmem_responder;
  localparam int ADDR_W = 6;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_CYC = 32'hF000_0000, A_CON = 32'hF000_0004, A_ST = 32'hF000_0008;
  logic clk = 0, reset = 1, MemWriteM = 0, con_ready = 0;
  logic [31:0] ALUOutM = 0, WriteDataM = 0, ReadDataM;
  logic [7:0] con_data;
  logic con_valid, err_misaligned;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic m_ovf = 0;
  dmem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .err_misaligned(err_misaligned)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWriteM = we;
    ALUOutM = a;
    WriteDataM = d;
  endtask
  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(q.size()), 5'h0, m_ovf, q.size() == FIFO_DEPTH, q.size() == 0};
  endfunction
  task automatic push_byte(input logic [7:0] b);
    drive(1, A_CON, {24'h0, b});
    if (q.size() < FIFO_DEPTH) q.push_back(b);
    else m_ovf = 1;
    step();
    drive(0, 0, 0);
  endtask
  task automatic test_reset();
    reset = 1;
    drive(0, A_ST, 0);
    step();
    step();
    checks++; if (ReadDataM !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp %h", ReadDataM, 32'h1); end
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", con_valid); end
    checks++; if (con_data !== 8'h0) begin errors++; $display("FAIL reset_data got %h exp 00", con_data); end
    checks++; if (err_misaligned !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_misaligned); end
    drive(0, A_CYC, 0);
    #1;
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp 0", ReadDataM); end
  endtask
  task automatic test_ram();
    drive(1, 32'h10, 32'h1111_1111);
    step();
    reset = 0;
    drive(1, 32'h10, 32'hDEAD_BEEF);
    #1;
    checks++; if (ReadDataM !== 32'h1111_1111) begin errors++; $display("FAIL ram_old_value got %h exp %h", ReadDataM, 32'h1111_1111); end
    step();
    drive(0, 32'h10, 0);
    #1;
    checks++; if (ReadDataM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read got %h exp %h", ReadDataM, 32'hDEAD_BEEF); end
    drive(0, 32'h110, 0);
    #1;
    checks++; if (ReadDataM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias got %h exp %h", ReadDataM, 32'hDEAD_BEEF); end
    drive(0, 32'hF000_000C, 0);
    #1;
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL mmio_0c got %h exp 0", ReadDataM); end
    drive(0, A_CON, 0);
    #1;
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL console_read got %h exp 0", ReadDataM); end
    step();
  endtask
  task automatic test_cycle();
    reset = 1;
    drive(0, 0, 0);
    step();
    reset = 0;
    q.delete();
    m_ovf = 0;
    repeat (100) step();
    drive(0, A_CYC, 0);
    #1;
    checks++; if (ReadDataM !== 32'd100) begin errors++; $display("FAIL cycle_100 got %0d exp 100", ReadDataM); end
    force dut.cycle = 32'hFFFF_FFFF;
    #1;
    checks++; if (ReadDataM !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_forced got %h exp ffffffff", ReadDataM); end
    release dut.cycle;
    step();
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL cycle_wrap got %h exp 0", ReadDataM); end
    step();
    checks++; if (ReadDataM !== 32'h1) begin errors++; $display("FAIL cycle_after_wrap got %h exp 1", ReadDataM); end
  endtask
  task automatic test_drain();
    con_ready = 1;
    drive(0, 0, 0);
    for (int c = 0; c < 4 * FIFO_DEPTH + 4 && q.size() != 0; c++) begin
      if (con_valid) begin
        checks++; if (con_data !== q[0]) begin errors++; $display("FAIL drain_data got %h exp %h", con_data, q[0]); end
        void'(q.pop_front());
      end
      step();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_timeout left %0d exp 0", q.size()); end
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", con_valid); end
    con_ready = 0;
    drive(0, A_ST, 0);
    #1;
    checks++; if (ReadDataM !== exp_status()) begin errors++; $display("FAIL drain_status got %h exp %h", ReadDataM, exp_status()); end
    step();
  endtask
  task automatic test_console();
    con_ready = 0;
    push_byte(8'h48);
    checks++; if (con_valid !== 1'b1) begin errors++; $display("FAIL push_latency got %b exp 1", con_valid); end
    push_byte(8'h69);
    drive(0, A_ST, 0);
    #1;
    checks++; if (ReadDataM !== exp_status()) begin errors++; $display("FAIL console_status got %h exp %h", ReadDataM, exp_status()); end
    step();
    step();
    checks++; if (con_data !== q[0]) begin errors++; $display("FAIL con_data_stable got %h exp %h", con_data, q[0]); end
    test_drain();
  endtask
  task automatic test_overflow();
    con_ready = 0;
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    drive(0, A_ST, 0);
    #1;
    checks++; if (ReadDataM !== exp_status()) begin errors++; $display("FAIL overflow_status got %h exp %h", ReadDataM, exp_status()); end
    drive(1, A_ST, 32'h4);
    m_ovf = 0;
    step();
    drive(0, A_ST, 0);
    #1;
    checks++; if (ReadDataM !== exp_status()) begin errors++; $display("FAIL ovf_clear_status got %h exp %h", ReadDataM, exp_status()); end
  endtask
  task automatic test_full_push_pop();
    con_ready = 1;
    drive(1, A_CON, 32'hAA);
    #1;
    checks++; if (con_data !== q[0]) begin errors++; $display("FAIL full_pop_oldest got %h exp %h", con_data, q[0]); end
    void'(q.pop_front());
    q.push_back(8'hAA);
    step();
    con_ready = 0;
    drive(0, A_ST, 0);
    #1;
    checks++; if (ReadDataM !== exp_status()) begin errors++; $display("FAIL full_push_pop_status got %h exp %h", ReadDataM, exp_status()); end
    step();
    test_drain();
  endtask
  task automatic test_reset_flush();
    con_ready = 0;
    push_byte(8'h31);
    push_byte(8'h32);
    reset = 1;
    drive(1, A_CON, 32'h77);
    step();
    reset = 0;
    drive(0, A_ST, 0);
    q.delete();
    m_ovf = 0;
    #1;
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", con_valid); end
    checks++; if (con_data !== 8'h0) begin errors++; $display("FAIL flush_data got %h exp 00", con_data); end
    checks++; if (ReadDataM !== exp_status()) begin errors++; $display("FAIL flush_status got %h exp %h", ReadDataM, exp_status()); end
    step();
  endtask
  task automatic test_misalign();
    logic [31:0] exp_word;
    logic exp_err;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_word = 32'h0123_4567;
    exp_err = 1;
`else
    exp_word = 32'h5555_AAAA;
    exp_err = 0;
`endif
    drive(1, 32'h10, 32'h0123_4567);
    step();
    drive(1, 32'h12, 32'h5555_AAAA);
    step();
    drive(0, 32'h10, 0);
    repeat (3) step();
    checks++; if (ReadDataM !== exp_word) begin errors++; $display("FAIL misalign_ram got %h exp %h", ReadDataM, exp_word); end
    checks++; if (err_misaligned !== exp_err) begin errors++; $display("FAIL misalign_err got %b exp %b", err_misaligned, exp_err); end
    reset = 1;
    step();
    reset = 0;
    checks++; if (err_misaligned !== 1'b0) begin errors++; $display("FAIL misalign_reset got %b exp 0", err_misaligned); end
  endtask
  initial begin
    test_reset();
    test_ram();
    test_cycle();
    test_console();
    test_overflow();
    test_full_push_pop();
    test_reset_flush();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the pipelined ARM core's memory stage.
- Inputs from the core: MemWriteM, ALUOutM (address), WriteDataM.
- Returns ReadDataM to the core in the same cycle.
- Word RAM lives below 0xF000_0000. An MMIO window at 0xF000_0000 holds a free-running cycle counter, a console TX FIFO and a status register.
- The console FIFO drains through a valid/ready byte stream to the testbench or a UART.

Parameters:
- ADDR_W, 6, RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- FIFO_DEPTH, 8, console FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWriteM  input  1  store strobe from the core's M stage.
- ALUOutM  input  32  byte address from the core.
- WriteDataM  input  32  store data from the core.
- ReadDataM  output  32  load data to the core; combinational.
- con_data  output  8  head byte of the console FIFO.
- con_valid  output  1  FIFO not empty.
- con_ready  input  1  consumer accepts con_data when con_valid && con_ready.
- err_misaligned  output  1  sticky misaligned-access flag.

Behaviour:
- Decode:
  - mmio = (ALUOutM[31:28] == 4'hF).
  - RAM index = ALUOutM[ADDR_W+1:2]; higher non-MMIO address bits are ignored, so the RAM aliases.
- RAM write: on the edge where MemWriteM && !mmio, RAM[index] <= WriteDataM.
- RAM read: ReadDataM = RAM[index] combinationally. A read of a location written in this same cycle returns the old value.
- RAM contents are not cleared by reset.
- MMIO registers (offset = ALUOutM[3:0]; ALUOutM[27:4] ignored):
  - 0x0 CYCLE, read-only. 32-bit counter, reset 0, +1 every cycle, wraps 0xFFFF_FFFF -> 0. A read returns the pre-edge value. Writes are ignored.
  - 0x4 CONSOLE. A write pushes WriteDataM[7:0] into the FIFO. Reads return 0.
  - 0x8 STATUS. Read = {16'b0, count[7:0], 5'b0, ovf, full, empty}. A write with WriteDataM[2]=1 clears ovf; other bits are ignored.
  - 0xC and any other offset: reads return 0, writes are ignored.
- Console FIFO:
  - Push: MemWriteM && mmio && offset==0x4.
  - Pop: con_valid && con_ready.
  - Push while full (no pop that cycle): the byte is dropped and ovf <= 1. ovf is sticky until cleared by a STATUS write or reset.
  - Push and pop in the same cycle while full: both succeed; count is unchanged; no overflow.
  - Push while empty: con_valid rises on the next cycle. There is no fall-through, so latency is 1 cycle.
  - con_data is stable while con_valid && !con_ready.
  - count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
- Reset values: CYCLE=0, FIFO empty, con_valid=0, con_data=0, ovf=0, err_misaligned=0. ReadDataM follows its combinational decode.
- Reset while the FIFO is non-empty discards every entry. A push or write in the reset cycle is ignored for MMIO state only; a RAM write still occurs.

Optional Feature:
- DMEM_MISALIGN_CHECK_EN:
  - Defined: any cycle with MemWriteM && ALUOutM[1:0]!=0 suppresses the store (RAM and MMIO alike) and sets err_misaligned. The flag is sticky and cleared only by reset. Loads are not checked, because the responder cannot see a load strobe.
  - Undefined: ALUOutM[1:0] is ignored and err_misaligned is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - MMIO_BASE_NIBBLE = 4'hF.
  - Offsets OFF_CYCLE=4'h0, OFF_CONSOLE=4'h4, OFF_STATUS=4'h8.
  - STATUS bit positions ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=8.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) handles push/pop/count/full/empty and the simultaneous push/pop rule. It is instantiated once with WIDTH=8.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x10 -> ReadDataM=0xDEADBEEF. Load 0x0000_0110 (ADDR_W=6 alias) -> 0xDEADBEEF.
- Release reset, idle 100 cycles, load 0xF000_0000 -> 100 ± the fixed sampling offset documented by the bench. Force the counter to 0xFFFF_FFFF -> next cycle reads 0.
- Hold con_ready=0 and push 'H','i' to 0xF000_0004 -> STATUS=0x0000_0200. Raise con_ready -> con_data 0x48 then 0x69; con_valid=0 on the third cycle.
- con_ready=0, 9 pushes at FIFO_DEPTH=8 -> STATUS=0x0000_0806 and the 9th byte is lost. Write 0x4 to STATUS -> STATUS=0x0000_0802.
- FIFO full with con_ready=1 and a push in the same cycle -> count stays 8, ovf stays 0, and the popped byte is the oldest.
- With DMEM_MISALIGN_CHECK_EN: store to 0x0000_0012 -> RAM[4] unchanged and err_misaligned=1 until reset. Without the macro: the store lands in RAM[4] and err_misaligned=0.
